nibble_serial_addsub: RTL and testbench

//  Sequencer directly upstream of the 4-bit add/sub slice.
//  - Takes wide operands and feeds them to the slice one nibble per clock, LSB nibble first.
//  - Chains the carry/borrow between nibbles in a register.
//  - Collects the sum nibbles into a full-width result.
//  - Reports carry-out and signed overflow, using the slice's c4/v from the last nibble.

---
 rtl/nibble_serial_addsub.sv | 148 ++++++++++++++
 tb/tb_nibble_serial_addsub.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub.sv
// Wide adder/subtractor sequenced over an external 4-bit add/sub slice, one nibble per clock, LSB first.
// Optional `zero` result flag when ZERO_FLAG_EN is defined.
module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [4*NIBBLES-1:0]   opa,
  input  logic [4*NIBBLES-1:0]   opb,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry,
  output logic                   overflow,
`ifdef ZERO_FLAG_EN
  output logic                   zero,
`endif
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_c0,
  input  logic [3:0]             add_s,
  input  logic                   add_c4,
  input  logic                   add_v
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [IW-1:0]   idx_reg;
  logic            k_reg;
  logic            sub_reg;
  logic [W-1:0]    opa_reg;
  logic [W-1:0]    opb_reg;
  logic [W-1:0]    result_reg;
  logic [W-1:0]    result_next;
  logic            carry_reg;
  logic            overflow_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            last_nib;

  logic [3:0]      opa_nib [NIBBLES];
  logic [3:0]      opb_nib [NIBBLES];

  // Split the latched operands into nibbles and merge the slice output into the addressed result nibble.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign opa_nib[gi] = opa_reg[4*gi +: 4];
    assign opb_nib[gi] = opb_reg[4*gi +: 4];
    assign result_next[4*gi +: 4] = (idx_reg == IW'(gi)) ? add_s : result_reg[4*gi +: 4];
  end

  assign last_nib = (idx_reg == IW'(NIBBLES - 1));

  // The slice inverts b when c0=1, so pre-invert by s^k to present b^{s} with carry-in k.
  always_comb begin
    add_a  = 4'd0;
    add_b  = 4'd0;
    add_c0 = 1'b0;
    if (state_reg == RUN) begin
      add_a  = opa_nib[idx_reg];
      add_b  = opb_nib[idx_reg] ^ {4{sub_reg ^ k_reg}};
      add_c0 = k_reg;
    end
  end

`ifdef ZERO_FLAG_EN
  logic zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg <= 1'b0;
    end else if (state_reg == RUN && last_nib) begin
      zero_reg <= (result_next == '0);
    end
  end

  assign zero = zero_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      k_reg        <= 1'b0;
      sub_reg      <= 1'b0;
      opa_reg      <= '0;
      opb_reg      <= '0;
      result_reg   <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            opa_reg   <= opa;
            opb_reg   <= opb;
            sub_reg   <= op_sub;
            k_reg     <= op_sub;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          result_reg <= result_next;
          k_reg      <= add_c4;
          if (last_nib) begin
            carry_reg    <= add_c4;
            overflow_reg <= add_v;
            done_reg     <= 1'b1;
            state_reg    <= DONE;
          end else begin
            idx_reg <= idx_reg + IW'(1);
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign result   = result_reg;
  assign carry    = carry_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub with a behavioural 4-bit slice; covers `zero` when ZERO_FLAG_EN is defined.
module tb_nibble_serial_addsub;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          op_sub;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          carry;
  logic          overflow;
  logic          zero;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic          add_c0;
  logic [3:0]    add_s;
  logic          add_c4;
  logic          add_v;
  logic [3:0]    slice_bb;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .opa      (opa),
    .opb      (opb),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
`ifdef ZERO_FLAG_EN
    .zero     (zero),
`endif
    .add_a    (add_a),
    .add_b    (add_b),
    .add_c0   (add_c0),
    .add_s    (add_s),
    .add_c4   (add_c4),
    .add_v    (add_v)
  );

`ifndef ZERO_FLAG_EN
  assign zero = 1'b0;
`endif

  // Behavioural slice: a + (b ^ {4{c0}}) + c0, with signed overflow.
  assign slice_bb = add_b ^ {4{add_c0}};
  assign {add_c4, add_s} = {1'b0, add_a} + {1'b0, slice_bb} + {4'd0, add_c0};
  assign add_v = (add_a[3] == slice_bb[3]) && (add_s[3] != add_a[3]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t          e;
    logic [W:0]    s;
    logic [W-1:0]  bb;
    bb = sub ? ~b : b;
    s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    e.result   = s[W-1:0];
    e.carry    = s[W];
    e.overflow = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    e.zero     = (s[W-1:0] == '0);
    return e;
  endfunction

  // Scoreboard consumer: compares each completion against the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", result, mon_e.result);
        chk("carry", carry, mon_e.carry);
        chk("overflow", overflow, mon_e.overflow);
`ifdef ZERO_FLAG_EN
        chk("zero", zero, mon_e.zero);
`endif
        $display("txn result=%h carry=%b overflow=%b zero=%b (exp %h %b %b %b)",
                 result, carry, overflow, zero,
                 mon_e.result, mon_e.carry, mon_e.overflow, mon_e.zero);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_add_a"}, add_a, 0);
    chk({tag, "_add_b"}, add_b, 0);
    chk({tag, "_add_c0"}, add_c0, 0);
  endtask

  // Issue one operation from IDLE (called #1 after a rising edge); start cycle is cycle 0.
  task automatic do_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    int   n;
    exp_t e;
    e = model(sub, a, b);
    start  = 1'b1;
    op_sub = sub;
    opa    = a;
    opb    = b;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start  = 1'b0;
    opa    = W'($urandom);
    opb    = W'($urandom);
    op_sub = 1'($urandom);
    chk("busy_run", busy, 1);
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, NIBBLES + 1);
    // start raised in the DONE cycle must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_idle_outputs("after_done");
    chk("result_hold", result, e.result);
    chk("carry_hold", carry, e.carry);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int seen;
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sub = 1'b0;
    opa    = '0;
    opb    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_result", result, 0);
    chk("reset_carry", carry, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_zero", zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(1'b0, 16'h1234, 16'h0FCD);
    do_op(1'b1, 16'h0005, 16'h0007);
    do_op(1'b0, 16'h7FFF, 16'h0001);
    do_op(1'b1, 16'h8000, 16'h0001);
    do_op(1'b0, 16'hFFFF, 16'h0001);
    do_op(1'b1, 16'h1234, 16'h1234);
    for (int i = 0; i < 12; i++) begin
      do_op(1'($urandom), W'($urandom), W'($urandom));
    end

    // Abort mid-operation: second start during RUN is ignored, reset leaves no done pulse.
    start  = 1'b1;
    op_sub = 1'b0;
    opa    = 16'h1111;
    opb    = 16'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy", busy, 1);
    chk("abort_partial", result[7:0], 8'h33);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    chk("abort_result", result, 0);
    chk("abort_carry", carry, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_zero", zero, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("abort_no_activity", seen, 0);

    do_op(1'b0, 16'hA5A5, 16'h5A5B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
